// File: rtl/tohost_monitor.sv
// Snoops CPU data-memory stores: tracks the riscv-tests tohost word into pass/fail/timeout
// status and streams console-port bytes out through a small valid/ready FIFO.
module tohost_monitor #(
    parameter logic [31:0] TOHOST_ADDR  = 32'h0000_1000,
    parameter logic [31:0] CONSOLE_ADDR = 32'h0000_1004,
    parameter int unsigned MAX_CYCLES   = 200000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [30:0] fail_code,
    output logic [31:0] cycle_count,
    output logic        con_valid,
    output logic [7:0]  con_data,
    input  logic        con_ready,
    output logic [7:0]  con_drops
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [31:0]      LAST_CYCLE = 32'(MAX_CYCLES - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_tohost;

    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;

    logic             w_hitTh;
    logic             w_hitCon;
    logic [31:0]      w_thNext;
    logic             w_push;
    logic             w_pop;
    logic             w_full;
    logic             w_doPush;
    logic             w_drop;
    logic [PTR_W-1:0] w_rdNext;
    logic [CNT_W-1:0] w_countNext;
    logic [7:0]       w_headNext;
    logic             w_unusedAddrBits;

    // Byte offsets within the word are irrelevant to both decoders.
    assign w_unusedAddrBits = ^mem_addr[1:0];
    assign w_hitTh  = mem_we && (mem_addr[31:2] == TOHOST_ADDR[31:2]);
    assign w_hitCon = mem_we && (mem_addr[31:2] == CONSOLE_ADDR[31:2]);

    always_comb begin
        w_thNext = r_tohost;
        for (int i = 0; i < 4; i++) begin
            if (mem_wmask[i]) begin
                w_thNext[8*i +: 8] = mem_wdata[8*i +: 8];
            end
        end
    end

    // A tohost event wins over a timeout landing on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_RUN;
            r_tohost    <= 32'd0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_code   <= 31'd0;
            cycle_count <= 32'd0;
        end else if (r_state == ST_RUN) begin
            cycle_count <= cycle_count + 32'd1;
            if (w_hitTh) begin
                r_tohost <= w_thNext;
            end
            if (w_hitTh && (w_thNext == 32'd1)) begin
                r_state <= ST_PASS;
                done    <= 1'b1;
                pass    <= 1'b1;
            end else if (w_hitTh && (w_thNext != 32'd0)) begin
                r_state   <= ST_FAIL;
                done      <= 1'b1;
                fail      <= 1'b1;
                fail_code <= w_thNext[31:1];
            end else if (cycle_count == LAST_CYCLE) begin
                r_state <= ST_TIMEOUT;
                done    <= 1'b1;
                timeout <= 1'b1;
            end
        end
    end

    assign w_push   = w_hitCon && mem_wmask[0];
    assign w_pop    = con_valid && con_ready;
    assign w_full   = (r_count == FULL_COUNT);
    assign w_doPush = w_push && (!w_full || w_pop);
    assign w_drop   = w_push && w_full && !w_pop;
    assign w_rdNext = w_pop ? (r_rdPtr + PTR_W'(1)) : r_rdPtr;

    always_comb begin
        w_countNext = r_count;
        case ({w_doPush, w_pop})
            2'b10:   w_countNext = r_count + CNT_W'(1);
            2'b01:   w_countNext = r_count - CNT_W'(1);
            default: w_countNext = r_count;
        endcase
    end

    // The new head comes straight from wdata only when the push lands in the head slot.
    assign w_headNext = (w_doPush && (r_wrPtr == w_rdNext)) ? mem_wdata[7:0] : r_mem[w_rdNext];

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= mem_wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            con_valid <= 1'b0;
            con_data  <= 8'd0;
            con_drops <= 8'd0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            r_rdPtr   <= w_rdNext;
            r_count   <= w_countNext;
            con_valid <= (w_countNext != '0);
            con_data  <= w_headNext;
            if (w_drop && (con_drops != 8'hFF)) begin
                con_drops <= con_drops + 8'd1;
            end
        end
    end

endmodule

// File: doc/tohost_monitor.md
# tohost_monitor

Synthesizable bus snooper that sits directly downstream of `rv32i_cpu` on its data-memory write port, in parallel with `dmem`. It decodes CPU stores to the `tohost` word and to a console byte port. It turns the riscv-tests completion protocol into registered pass/fail/timeout status and streams console bytes through a small FIFO with a valid/ready handshake. Benches and FPGA top levels use it instead of peeking into `dmem` storage.

## Interface
- `TOHOST_ADDR`, default 32'h0000_1000: word address of `tohost`; bits [1:0] are ignored.
- `CONSOLE_ADDR`, default 32'h0000_1004: word address of the console byte port; bits [1:0] are ignored.
- `MAX_CYCLES`, default 200000: cycle budget before timeout; must be ≥ 2.
- `FIFO_DEPTH`, default 4: console FIFO entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  synchronous, active-high reset
- `mem_we`  in  1  CPU store strobe
- `mem_addr`  in  32  CPU store address
- `mem_wdata`  in  32  CPU store data
- `mem_wmask`  in  4  byte-lane enables; bit i covers wdata[8i+7:8i]
- `done`  out  1  a terminal state has been reached
- `pass`  out  1  tohost == 1 was observed
- `fail`  out  1  nonzero tohost ≠ 1 was observed
- `timeout`  out  1  budget exhausted with no tohost event
- `fail_code`  out  31  tohost[31:1] captured at failure (failing test number)
- `cycle_count`  out  32  cycles spent in RUN
- `con_valid`  out  1  console FIFO is non-empty
- `con_data`  out  8  FIFO head byte
- `con_ready`  in  1  consumer accepts the head byte
- `con_drops`  out  8  console bytes lost to overflow; saturates at 255

## Operation
- Address decode: `hit_th = mem_we && mem_addr[31:2] == TOHOST_ADDR[31:2]`; `hit_con` uses the same form with `CONSOLE_ADDR`.
- Shadow `tohost` register, reset to 0:
  - On `hit_th`, each byte lane whose `wmask` bit is set is replaced by the matching `wdata` lane.
  - `th_next` is the merged value.
- State machine, 2-bit, with states RUN, PASS, FAIL and TIMEOUT. Reset goes to RUN. All states except RUN are terminal.
- RUN transitions, with tohost taking priority over timeout:
  - `hit_th` and `th_next` == 1 → PASS.
  - `hit_th` and `th_next` ∉ {0, 1} → FAIL; `fail_code` ← `th_next[31:1]`.
  - `hit_th` and `th_next` == 0 → remain in RUN. Partial writes that leave the merged value at zero are not events.
  - Otherwise, if `cycle_count` == MAX_CYCLES−1 → TIMEOUT.
- `cycle_count` increments by 1 on every edge spent in RUN, including the edge that leaves RUN. It is frozen in terminal states.
- In terminal states, tohost writes are ignored: no shadow update and no state change.
- `done` = state ≠ RUN. `pass`, `fail` and `timeout` are one-hot decodes of the state, all registered.
- Console port:
  - Push: `hit_con` with `wmask[0]` = 1 pushes `wdata[7:0]`. A hit with `wmask[0]` = 0 is ignored.
  - Pop: `con_valid && con_ready`.
  - The console stays active in all states so the final output drains after `done`.
- FIFO boundaries:
  - Full, push without pop: the byte is dropped and `con_drops` increments, saturating at 255.
  - Full with push and pop in the same cycle: both occur; no drop; count unchanged.
  - Empty with a push: `con_valid` rises the next cycle. There is no bypass.
  - Pointers wrap modulo FIFO_DEPTH. Occupancy is tracked with a `log2(FIFO_DEPTH)+1`-bit count.
- A single address cannot hit both decoders; equal parameter addresses are illegal.

## Timing
- Reset values: state RUN; `done`, `pass`, `fail` and `timeout` 0; `fail_code` 0; `cycle_count` 0; shadow `tohost` 0; FIFO empty; `con_valid` 0; `con_data` 0; `con_drops` 0.
- Reset asserted mid-run or in a terminal state returns everything to the reset values on the next edge and discards FIFO contents.
- Status latency: 1 cycle. A tohost store sampled at edge N gives `done`/`pass`/`fail` high immediately after edge N, matching `dmem`'s write commit edge.
- Timeout: with reset released before edge 0, `timeout` rises after edge MAX_CYCLES−1, with `cycle_count` = MAX_CYCLES.
- Console: a byte pushed at edge N is visible on `con_data` after N if the FIFO was empty. Otherwise it follows the FIFO order.
- `con_data` is registered from the head entry and held stable while `con_valid && !con_ready`.

## Test plan
- Full-word store of 1 to 0x1000 at cycle 10 → `pass` = 1 and `done` = 1 from cycle 11; `cycle_count` = 11; further stores of 7 to 0x1000 leave `pass` = 1 and `fail_code` = 0.
- Store 0x0000_0007 with wmask 4'b0001 → `fail` = 1, `fail_code` = 3. Then pulse `reset` → all outputs 0 and state back to RUN.
- Byte store 0x00 to 0x1001 with mask 4'b0010 → no event. A following mask 4'b0001 store of 0x01 → `pass`.
- MAX_CYCLES = 50 with no stores → `timeout` = 1 after edge 49, `cycle_count` = 50. Variant: a pass store sampled on edge 49 → `pass` only, `timeout` stays 0.
- FIFO_DEPTH = 4, `con_ready` = 0, push 'A','B','C','D','E' → `con_drops` = 1. Raise `con_ready` → 'A','B','C','D' emerge in order, then `con_valid` = 0.
- Full FIFO with a push and `con_ready` = 1 in the same cycle → `con_drops` unchanged and the new byte emerges last. Store to 0x1004 with mask 4'b0010 → no push.
